muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS CPU.
- Operands come straight from the register file read ports (rs → a, rt → b).
- MFHI/MFLO results return to the register file write port through the writeback mux.
- The controller starts the unit for MULT/MULTU/DIV/DIVU, stalls on busy, and uses hi_wr/lo_wr for MTHI/MTLO.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Counter must hold the value WIDTH itself, hence one extra bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(32);

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    op_e                op_q;
    logic               a_neg_q, b_neg_q;
    logic [WIDTH-1:0]   dvs_q;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_hi_q;   // product high half / partial remainder
    logic [WIDTH-1:0]   acc_lo_q;   // multiplier / dividend-quotient shift register
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, busy_q;

    logic               a_neg_c, b_neg_c;
    logic [WIDTH-1:0]   a_mag_c, b_mag_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     div_sh_c;
    logic               div_ge_c;
    logic [WIDTH-1:0]   div_diff_c;
    logic [2*WIDTH-1:0] prod_c, prod_fix_c;
    logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;

    // Operand sign flags and magnitudes; sign only matters for signed ops.
    always_comb begin
        a_neg_c = op[0] & a[WIDTH-1];
        b_neg_c = op[0] & b[WIDTH-1];
        a_mag_c = a_neg_c ? (~a + WIDTH'(1)) : a;
        b_mag_c = b_neg_c ? (~b + WIDTH'(1)) : b;
    end

    // One shift-add or restoring-subtract step on the accumulators.
    always_comb begin
        mul_sum_c  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvs_q} : '0);
        div_sh_c   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge_c   = (div_sh_c >= {1'b0, dvs_q});
        div_diff_c = div_sh_c[WIDTH-1:0] - dvs_q;
    end

    // Sign correction of the raw magnitude result.
    always_comb begin
        prod_c     = {acc_hi_q, acc_lo_q};
        prod_fix_c = (a_neg_q ^ b_neg_q) ? (~prod_c + (2*WIDTH)'(1)) : prod_c;
        quo_fix_c  = (a_neg_q ^ b_neg_q) ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
        rem_fix_c  = a_neg_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath, HI/LO registers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= OP_MULTU;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            dvs_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= (state_q == S_FIX);
            busy_q <= (state_d != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (hi_wr) hi_q <= wr_din;
                    if (lo_wr) lo_q <= wr_din;
                    if (start) begin
                        op_q     <= op_e'(op);
                        a_neg_q  <= a_neg_c;
                        b_neg_q  <= b_neg_c;
                        cnt_q    <= '0;
                        acc_hi_q <= '0;
                        if (op[1]) begin
                            dvs_q    <= b_mag_c;
                            acc_lo_q <= a_mag_c;
                        end else begin
                            dvs_q    <= a_mag_c;
                            acc_lo_q <= b_mag_c;
                        end
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (op_q[1]) begin
                        acc_hi_q <= div_ge_c ? div_diff_c : div_sh_c[WIDTH-1:0];
                        acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge_c};
                    end else begin
                        acc_hi_q <= mul_sum_c[WIDTH:1];
                        acc_lo_q <= {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (op_q[1]) begin
                        hi_q <= rem_fix_c;
                        lo_q <= quo_fix_c;
                    end else begin
                        hi_q <= prod_fix_c[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix_c[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_wr, lo_wr;
    logic [31:0] wr_din;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_wr  (hi_wr),
        .lo_wr  (lo_wr),
        .wr_din (wr_din),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an operation, scramble operands afterwards, check timing and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int edges;
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        a = ~av; b = ~bv;
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            if (!busy) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s busy at edge E%0d: got 0 want 1", name, i - 1);
            end
            tick();
            if (done) begin
                edges = i;
                break;
            end
        end
        n_cmp++;
        if (edges !== 33) begin
            n_bad++;
            $display("FAIL %s done edge: got E%0d want E33", name, edges);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy with done: got %b want 0", name, busy);
        end
        n_cmp++;
        if (hi !== exp_hi) begin
            n_bad++;
            $display("FAIL %s hi: got %h want %h", name, hi, exp_hi);
        end
        n_cmp++;
        if (lo !== exp_lo) begin
            n_bad++;
            $display("FAIL %s lo: got %h want %h", name, lo, exp_lo);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done width: got %b want 0 one cycle later", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wr_din = '0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_mul();
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_op(2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5");
        run_op(2'b01, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, "mult_neg3xneg5");
        run_op(2'b00, 32'h80000000, 32'd4,        32'h00000002, 32'h00000000, "multu_shift");
    endtask

    task automatic test_div();
        run_op(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow");
        run_op(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100by7");
        run_op(2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7byneg2");
    endtask

    task automatic test_div_zero();
        run_op(2'b10, 32'd100,      32'd0, 32'h00000064, 32'hFFFFFFFF, "divu_by0");
        run_op(2'b11, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'h00000001, "div_neg_by0");
        run_op(2'b11, 32'd9,        32'd0, 32'h00000009, 32'hFFFFFFFF, "div_pos_by0");
    endtask

    // DIVU 20/3 with a second start and an MTHI dropped at E10.
    task automatic test_busy_ignore();
        int edges;
        op = 2'b10; a = 32'd20; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9; hi_wr = 1'b1; wr_din = 32'h0000AAAA;
        tick();
        start = 1'b0; hi_wr = 1'b0;
        edges = 10;
        for (int i = 11; i <= 45; i++) begin
            tick();
            if (done) begin
                edges = i;
                break;
            end
        end
        n_cmp++;
        if (edges !== 33) begin
            n_bad++;
            $display("FAIL busy_ignore done edge: got E%0d want E33", edges);
        end
        n_cmp++;
        if (hi !== 32'd2 || lo !== 32'd6) begin
            n_bad++;
            $display("FAIL busy_ignore result: got hi=%h lo=%h want hi=2 lo=6", hi, lo);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignore relaunch: got busy=%b want 0", busy);
        end
        lo_wr = 1'b1; wr_din = 32'h00001234;
        tick();
        lo_wr = 1'b0;
        n_cmp++;
        if (lo !== 32'h00001234 || hi !== 32'd2) begin
            n_bad++;
            $display("FAIL mtlo_idle: got hi=%h lo=%h want hi=2 lo=1234", hi, lo);
        end
    endtask

    task automatic test_mthi_hold();
        hi_wr = 1'b1; wr_din = 32'h00000055;
        tick();
        hi_wr = 1'b0; wr_din = 32'hFFFF0000;
        tick();
        tick();
        n_cmp++;
        if (hi !== 32'h00000055 || lo !== 32'h00001234) begin
            n_bad++;
            $display("FAIL mthi_hold: got hi=%h lo=%h want hi=55 lo=1234", hi, lo);
        end
        // MTHI/MTLO in the start cycle are overwritten by the result.
        hi_wr = 1'b1; lo_wr = 1'b1; wr_din = 32'hDEADBEEF;
        run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, "start_with_mt");
    endtask

    // Reset in the middle of a MULT, then a clean follow-up operation.
    task automatic test_reset_mid();
        op = 2'b01; a = 32'hFFFFFFFD; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 14; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        tick();
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid idle: got busy=%b done=%b want 0 0", busy, done);
        end
        run_op(2'b01, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, "after_reset");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_mthi_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
